// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter.
// Words enter a small FIFO through a write strobe. Each word is sent as a
// start bit, DATA_BITS data bits LSB first, an optional parity bit, and one
// or two stop bits. Frames run back-to-back while the FIFO holds data.
module uart_tx #(
  parameter int CLOCK_RATE     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = CLOCK_RATE / BAUD_RATE,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_write,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_busy,
  output logic                          o_tx_w
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 full_q;

  // Serialiser state
  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 busy_q;

  // Handshake between FIFO and serialiser
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;
  logic [DATA_BITS-1:0] head;

  // Decide push/pop for this edge and the resulting word count.
  always_comb begin
    bit_end   = (baud_q == '0);
    last_stop = (STOP_BITS == 1) ? 1'b1 : stop_q;
    head      = mem_q[rd_ptr_q];
    // A write while full is dropped even if a pop frees a slot on this edge.
    push      = i_write && !full_q;
    pop       = 1'b0;
    if (count_q != '0) begin
      if (state_q == S_IDLE) begin
        pop = 1'b1;
      end else if (state_q == S_STOP && bit_end && last_stop) begin
        pop = 1'b1;
      end
    end
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // FIFO pointers, occupancy and full flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
    end
  end

  // Frame FSM with baud timing and registered line/busy outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= BAUD_RELOAD;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= BAUD_RELOAD;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q  <= head;
            parity_q <= (PARITY_ODD != 0) ? ~^head : ^head;
            state_q  <= S_START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_q  <= BAUD_RELOAD;
            idx_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_q <= BAUD_RELOAD;
            if (idx_q == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= S_STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_q <= BAUD_RELOAD;
            if (!last_stop) begin
              stop_q <= 1'b1;
            end else if (pop) begin
              // Next word is already queued: go straight to its start bit.
              shift_q  <= head;
              parity_q <= (PARITY_ODD != 0) ? ~^head : ^head;
              state_q  <= S_START;
              tx_q     <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= BAUD_RELOAD;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_full  = full_q;
  assign o_count = count_q;
  assign o_busy  = busy_q;
  assign o_tx_w  = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O2) share one stimulus
// stream. Each has a frame-level reference model (word queue plus a position
// counter into the current frame) checked every cycle, plus literal checks.
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;
  localparam int NCFG  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr    = 1'b0;
  logic [DB-1:0] din   = '0;

  logic            tx_a   [NCFG];
  logic            busy_a [NCFG];
  logic            full_a [NCFG];
  logic [CNTW-1:0] cnt_a  [NCFG];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int PE   = (g == 0) ? 0 : 1;
    localparam int PO   = (g == 2) ? 1 : 0;
    localparam int SB   = (g == 0) ? 1 : 2;
    localparam int FLEN = (1 + DB + PE + SB) * CPB;

    uart_tx #(
      .CLOCK_RATE    (CPB * 9600),
      .BAUD_RATE     (9600),
      .DATA_BITS     (DB),
      .CYCLES_PER_BIT(CPB),
      .FIFO_DEPTH    (DEPTH),
      .PARITY_EN     (PE),
      .PARITY_ODD    (PO),
      .STOP_BITS     (SB)
    ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_data (din),
      .i_write(wr),
      .o_full (full_a[g]),
      .o_count(cnt_a[g]),
      .o_busy (busy_a[g]),
      .o_tx_w (tx_a[g])
    );

    logic [DB-1:0] mq [$];
    bit            m_act;
    logic [DB-1:0] m_cur;
    int            m_pos;
    bit            m_acc;

    // Line level at clock p of a frame carrying word w.
    function automatic logic fbit(input logic [DB-1:0] w, input int p);
      int idx;
      idx = p / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= DB) return w[idx-1];
      if (PE != 0 && idx == DB + 1) return (PO != 0) ? ~^w : ^w;
      return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mq.delete();
        m_act = 1'b0;
        m_pos = 0;
      end else begin
        m_acc = wr && (mq.size() < DEPTH);
        if (m_act && m_pos == FLEN - 1) m_act = 1'b0;
        else if (m_act) m_pos++;
        if (!m_act && mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_act = 1'b1;
          m_pos = 0;
        end
        if (m_acc) mq.push_back(din);
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("cfg%0d tx", g), tx_a[g], m_act ? fbit(m_cur, m_pos) : 1'b1);
        check($sformatf("cfg%0d busy", g), busy_a[g], m_act);
        check($sformatf("cfg%0d count", g), cnt_a[g], mq.size());
        check($sformatf("cfg%0d full", g), full_a[g], (mq.size() == DEPTH) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [DB-1:0] d);
    wr  = 1'b1;
    din = d;
    tick();
    wr  = 1'b0;
  endtask

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      if (busy_a[i] || cnt_a[i] != '0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 3000 && !all_idle()) begin
      tick();
      n++;
    end
    check({nm, " drain"}, all_idle(), 1);
  endtask

  task automatic check_reset_state(input string nm);
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("%s cfg%0d tx", nm, i), tx_a[i], 1);
      check($sformatf("%s cfg%0d busy", nm, i), busy_a[i], 0);
      check($sformatf("%s cfg%0d count", nm, i), cnt_a[i], 0);
      check($sformatf("%s cfg%0d full", nm, i), full_a[i], 0);
    end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic pat_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   rates  [3]  = '{3, 15, 70};
    int   nb [NCFG];

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check_reset_state("reset");

    // Idle with no writes.
    repeat (200) @(posedge clk);
    #1;
    check_reset_state("idle200");

    // Single word 0xA5.
    wr_word(8'hA5);
    @(posedge clk);
    for (int i = 0; i < NCFG; i++) nb[i] = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (k < 100) check($sformatf("a5 bit k=%0d", k), tx_a[0], pat_a5[k / 10]);
      for (int i = 0; i < NCFG; i++) if (busy_a[i]) nb[i]++;
    end
    check("a5 busy clocks", nb[0], 100);
    @(posedge clk);
    #1;
    wait_idle("a5");

    // Word 0x07: parity and two stop bits.
    wr_word(8'h07);
    @(posedge clk);
    for (int i = 0; i < NCFG; i++) nb[i] = 0;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      if (k == 95) begin
        check("07 even parity bit", tx_a[1], 1);
        check("07 odd parity bit", tx_a[2], 0);
      end
      for (int i = 0; i < NCFG; i++) if (busy_a[i]) nb[i]++;
    end
    check("07 8N1 clocks", nb[0], 100);
    check("07 8E2 clocks", nb[1], 120);
    check("07 8O2 clocks", nb[2], 120);
    @(posedge clk);
    #1;
    wait_idle("07");

    // Write on the same edge the stop state pops the next word.
    wr_word(8'h3C);
    wr_word(8'hC3);
    check("sim idle-pop count", cnt_a[0], 1);
    repeat (99) @(posedge clk);
    #1;
    check("sim pre count", cnt_a[0], 1);
    check("sim pre busy", busy_a[0], 1);
    wr_word(8'h5A);
    check("sim post count", cnt_a[0], 1);
    check("sim post start", tx_a[0], 0);
    check("sim post busy", busy_a[0], 1);
    wait_idle("sim");

    // Burst of five words, sixth dropped while full.
    for (int d = 1; d <= 5; d++) wr_word(DB'(d));
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("burst5 cfg%0d full", i), full_a[i], 1);
      check($sformatf("burst5 cfg%0d count", i), cnt_a[i], 4);
    end
    wr_word(8'h06);
    check("burst6 full", full_a[0], 1);
    check("burst6 count", cnt_a[0], 4);
    nb[0] = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (busy_a[0]) nb[0]++;
    end
    check("burst busy clocks", nb[0], 496);
    @(posedge clk);
    #1;
    wait_idle("burst");

    // Reset during data bit 3 with two words queued.
    wr_word(8'h11);
    wr_word(8'h22);
    wr_word(8'h33);
    repeat (43) @(posedge clk);
    #3;
    check("midrst pre count", cnt_a[0], 2);
    check("midrst pre busy", busy_a[0], 1);
    check("midrst pre bit3", tx_a[0], 0);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst async");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check_reset_state("midrst after");

    // Randomised traffic with varying write density and one async reset.
    for (int it = 0; it < 4000; it++) begin
      if (it == 2500) begin
        wr = 1'b0;
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        check_reset_state("rand rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      wr  = ($urandom_range(0, 99) < rates[(it / 500) % 3]);
      din = DB'($urandom);
      tick();
    end
    wr = 1'b0;
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
